// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings and DMA state type shared by the initiator
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_D = 3'd2,
        WR_A = 3'd3,
        WR_D = 3'd4,
        ERR  = 3'd5
    } dma_state_t;

endpackage

// File: rtl/ahblite_dma_master.sv
// rtl/ahblite_dma_master.sv - AHB-Lite block-copy initiator; AHB_DMA_FILL_EN adds a constant-fill mode
module ahblite_dma_master
    import ahb_pkg::*;
#(
    parameter int         LEN_WIDTH = 16,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [31:0]          cmd_src,
    input  logic [31:0]          cmd_dst,
    input  logic [LEN_WIDTH-1:0] cmd_len,
`ifdef AHB_DMA_FILL_EN
    input  logic                 cmd_fill,
    input  logic [31:0]          cmd_pattern,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [3:0]           HPROT,
    output logic                 HMASTLOCK,
    output logic [31:0]          HWDATA,
    input  logic [31:0]          HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP
);

    dma_state_t           r_state;
    dma_state_t           w_next;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [LEN_WIDTH-1:0] r_len;
    logic [31:0]          r_buf;
    logic                 r_fill;
    logic                 r_zero_done;
    logic                 w_done;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_fill_cmd;
    logic [31:0]          w_fill_data;

`ifdef AHB_DMA_FILL_EN
    assign w_fill_cmd  = cmd_fill;
    assign w_fill_data = cmd_pattern;
`else
    assign w_fill_cmd  = 1'b0;
    assign w_fill_data = 32'h0;
`endif

    assign w_accept = (r_state == IDLE) && cmd_valid;

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            IDLE: if (w_accept && (cmd_len != '0)) w_next = w_fill_cmd ? WR_A : RD_A;
            RD_A: if (HREADY) w_next = RD_D;
            RD_D: begin
                // First ERROR cycle has HREADY low; finish the two-cycle response in ERR
                if (HRESP == HRESP_ERROR) begin
                    if (HREADY) begin
                        w_err  = 1'b1;
                        w_next = IDLE;
                    end else begin
                        w_next = ERR;
                    end
                end else if (HREADY) begin
                    w_next = WR_A;
                end
            end
            WR_A: if (HREADY) w_next = WR_D;
            WR_D: begin
                if (HRESP == HRESP_ERROR) begin
                    if (HREADY) begin
                        w_err  = 1'b1;
                        w_next = IDLE;
                    end else begin
                        w_next = ERR;
                    end
                end else if (HREADY) begin
                    if (r_len == LEN_WIDTH'(1)) begin
                        w_done = 1'b1;
                        w_next = IDLE;
                    end else begin
                        w_next = r_fill ? WR_A : RD_A;
                    end
                end
            end
            ERR: begin
                if (HREADY) begin
                    w_err  = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= IDLE;
            r_src       <= 32'h0;
            r_dst       <= 32'h0;
            r_len       <= '0;
            r_buf       <= 32'h0;
            r_fill      <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_zero_done <= w_accept && (cmd_len == '0);
            if (w_accept) begin
                r_src  <= {cmd_src[31:2], 2'b00};
                r_dst  <= {cmd_dst[31:2], 2'b00};
                r_len  <= cmd_len;
                r_fill <= w_fill_cmd;
                if (w_fill_cmd) r_buf <= w_fill_data;
            end
            if ((r_state == RD_D) && HREADY && (HRESP == HRESP_OKAY)) r_buf <= HRDATA;
            if ((r_state == WR_D) && HREADY && (HRESP == HRESP_OKAY)) begin
                r_src <= r_src + 32'd4;
                r_dst <= r_dst + 32'd4;
                r_len <= r_len - LEN_WIDTH'(1);
            end
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = w_done | r_zero_done;
    assign err       = w_err;
    assign HTRANS    = ((r_state == RD_A) || (r_state == WR_A)) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWRITE    = (r_state == WR_A) || (r_state == WR_D);
    assign HADDR     = HWRITE ? r_dst : r_src;
    assign HWDATA    = r_buf;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

endmodule
